// File: rtl/paddle_bbox_locator.sv
// paddle_bbox_locator: per-frame paddle bounding-box, centre and pixel-count
// extractor working on a raster-ordered binary mask stream. Only horizontal
// runs of at least RUN_MIN mask pixels contribute, which filters out
// isolated noise pixels.
module paddle_bbox_locator #(
   parameter int WIDTH      = 640,
   parameter int HEIGHT     = 480,
   parameter int RUN_MIN    = 4,
   parameter int MIN_PIXELS = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        EN,
   input  logic        frame_start,
   input  logic        mask_in,
   output logic        result_valid,
   output logic        found,
   output logic [9:0]  min_x,
   output logic [9:0]  max_x,
   output logic [9:0]  min_y,
   output logic [9:0]  max_y,
   output logic [9:0]  center_x,
   output logic [9:0]  center_y,
   output logic [18:0] pixel_count
);

   localparam int              RW       = (RUN_MIN < 1) ? 1 : $clog2(RUN_MIN + 1);
   localparam logic [9:0]      X_LAST   = 10'(WIDTH - 1);
   localparam logic [9:0]      Y_LAST   = 10'(HEIGHT - 1);
   localparam logic [RW-1:0]   RUN_TOP  = RW'(RUN_MIN);
   localparam logic [RW-1:0]   RUN_PRE  = RW'(RUN_MIN - 1);
   localparam logic [9:0]      RUN_BACK = 10'(RUN_MIN - 1);
   localparam logic [19:0]     RUN_ADD  = 20'(RUN_MIN);
   localparam logic [18:0]     CNT_SAT  = '1;
   localparam logic [18:0]     CNT_MIN  = 19'(MIN_PIXELS);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [9:0]      r_x, r_y;
   logic [RW-1:0]   r_run;
   logic [18:0]     r_cnt;
   logic [9:0]      r_min_x, r_max_x, r_min_y, r_max_y;

   // frame_start-adjusted view of the accumulator state for this cycle
   logic [9:0]      w_x, w_y;
   logic [RW-1:0]   w_run;
   logic [18:0]     w_cnt;
   logic [9:0]      w_min_x, w_max_x, w_min_y, w_max_y;

   // state after consuming the current pixel
   logic [9:0]      w_x_nxt, w_y_nxt;
   logic [RW-1:0]   w_run_nxt;
   logic [18:0]     w_cnt_nxt;
   logic [9:0]      w_min_x_nxt, w_max_x_nxt, w_min_y_nxt, w_max_y_nxt;

   logic            w_pix;
   logic            w_last;
   logic            w_reach;
   logic            w_ext;
   logic [9:0]      w_run_start;
   logic [19:0]     w_sum;
   logic            w_found;
   logic [10:0]     w_sum_cx, w_sum_cy;

   // A frame_start pulse makes this cycle see a freshly cleared frame, so a
   // pixel arriving with it is handled as (0,0) of the new frame.
   always_comb begin
      w_x     = r_x;
      w_y     = r_y;
      w_run   = r_run;
      w_cnt   = r_cnt;
      w_min_x = r_min_x;
      w_max_x = r_max_x;
      w_min_y = r_min_y;
      w_max_y = r_max_y;
      if (frame_start) begin
         w_x     = '0;
         w_y     = '0;
         w_run   = '0;
         w_cnt   = '0;
         w_min_x = '1;
         w_max_x = '0;
         w_min_y = '1;
         w_max_y = '0;
      end
   end

   assign w_pix       = EN && (frame_start || (r_state == ACCUM));
   assign w_last      = (w_x == X_LAST) && (w_y == Y_LAST);
   assign w_reach     = mask_in && (w_run == RUN_PRE);
   assign w_ext       = mask_in && (w_run == RUN_TOP);
   assign w_run_start = w_x - RUN_BACK;

   // Per-pixel update: raster position, run length, count and box candidates.
   // A run that reaches RUN_MIN is credited all at once; later pixels of the
   // same run add one each and push max_x.
   always_comb begin
      w_x_nxt     = w_x;
      w_y_nxt     = w_y;
      w_run_nxt   = w_run;
      w_min_x_nxt = w_min_x;
      w_max_x_nxt = w_max_x;
      w_min_y_nxt = w_min_y;
      w_max_y_nxt = w_max_y;

      if (!mask_in)
         w_run_nxt = '0;
      else if (!w_ext)
         w_run_nxt = w_run + RW'(1);

      if (w_x == X_LAST) begin
         w_x_nxt   = '0;
         w_y_nxt   = w_y + 10'd1;
         w_run_nxt = '0;              // runs never wrap across lines
      end else begin
         w_x_nxt   = w_x + 10'd1;
      end

      w_sum     = {1'b0, w_cnt} + (w_reach ? RUN_ADD : (w_ext ? 20'd1 : 20'd0));
      w_cnt_nxt = w_sum[19] ? CNT_SAT : w_sum[18:0];

      if (w_reach) begin
         if (w_run_start < w_min_x) w_min_x_nxt = w_run_start;
         if (w_y < w_min_y)         w_min_y_nxt = w_y;
         if (w_y > w_max_y)         w_max_y_nxt = w_y;
      end
      if (w_ext && (w_x > w_max_x))
         w_max_x_nxt = w_x;
   end

   // FSM next state; frame_start wins from any state (abort / back-to-back)
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = IDLE;
         ACCUM:   if (w_pix && w_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
      if (frame_start)
         w_state_nxt = (w_pix && w_last) ? DONE : ACCUM;
   end

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Accumulators: advance on a consumed pixel, clear on a bare frame_start
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_x     <= '0;
         r_y     <= '0;
         r_run   <= '0;
         r_cnt   <= '0;
         r_min_x <= '1;
         r_max_x <= '0;
         r_min_y <= '1;
         r_max_y <= '0;
      end else if (w_pix) begin
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_run   <= w_run_nxt;
         r_cnt   <= w_cnt_nxt;
         r_min_x <= w_min_x_nxt;
         r_max_x <= w_max_x_nxt;
         r_min_y <= w_min_y_nxt;
         r_max_y <= w_max_y_nxt;
      end else if (frame_start) begin
         r_x     <= w_x;
         r_y     <= w_y;
         r_run   <= w_run;
         r_cnt   <= w_cnt;
         r_min_x <= w_min_x;
         r_max_x <= w_max_x;
         r_min_y <= w_min_y;
         r_max_y <= w_max_y;
      end
   end

   assign w_found  = (r_cnt >= CNT_MIN);
   assign w_sum_cx = {1'b0, r_min_x} + {1'b0, r_max_x};
   assign w_sum_cy = {1'b0, r_min_y} + {1'b0, r_max_y};

   // Publish the completed frame at the end of DONE; hold until next DONE
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_valid <= 1'b0;
         found        <= 1'b0;
         min_x        <= '0;
         max_x        <= '0;
         min_y        <= '0;
         max_y        <= '0;
         center_x     <= '0;
         center_y     <= '0;
         pixel_count  <= '0;
      end else begin
         result_valid <= (r_state == DONE);
         if (r_state == DONE) begin
            found       <= w_found;
            pixel_count <= r_cnt;
            if (w_found) begin
               min_x    <= r_min_x;
               max_x    <= r_max_x;
               min_y    <= r_min_y;
               max_y    <= r_max_y;
               center_x <= 10'(w_sum_cx >> 1);
               center_y <= 10'(w_sum_cy >> 1);
            end else begin
               min_x    <= '0;
               max_x    <= '0;
               min_y    <= '0;
               max_y    <= '0;
               center_x <= '0;
               center_y <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_paddle_bbox_locator.sv
// tb_paddle_bbox_locator: two instances (tiny raster and a larger raster with
// the default run/pixel thresholds) driven from one shared stimulus bus.
module tb_paddle_bbox_locator;

   localparam int SW = 8,   SH = 4,  SR = 2, SM = 3;
   localparam int BW = 208, BH = 62, BR = 4, BM = 64;

   typedef struct {
      int f, mnx, mxx, mny, mxy, cx, cy, cnt, cyc;
   } res_t;

   logic clock = 1'b0;
   logic rst, en, fs, mk, sel;
   int   cyc = 0;
   int   nchk = 0, nfail = 0;

   bit   fr [0:63][0:255];
   res_t sq[$], bq[$];

   wire en_s = en & ~sel, fs_s = fs & ~sel;
   wire en_b = en &  sel, fs_b = fs &  sel;

   logic        s_rv, s_found, b_rv, b_found;
   logic [9:0]  s_mnx, s_mxx, s_mny, s_mxy, s_cx, s_cy;
   logic [9:0]  b_mnx, b_mxx, b_mny, b_mxy, b_cx, b_cy;
   logic [18:0] s_cnt, b_cnt;

   paddle_bbox_locator #(.WIDTH(SW), .HEIGHT(SH), .RUN_MIN(SR), .MIN_PIXELS(SM)) u_s (
      .clock(clock), .reset(rst), .EN(en_s), .frame_start(fs_s), .mask_in(mk),
      .result_valid(s_rv), .found(s_found), .min_x(s_mnx), .max_x(s_mxx),
      .min_y(s_mny), .max_y(s_mxy), .center_x(s_cx), .center_y(s_cy), .pixel_count(s_cnt));

   paddle_bbox_locator #(.WIDTH(BW), .HEIGHT(BH), .RUN_MIN(BR), .MIN_PIXELS(BM)) u_b (
      .clock(clock), .reset(rst), .EN(en_b), .frame_start(fs_b), .mask_in(mk),
      .result_valid(b_rv), .found(b_found), .min_x(b_mnx), .max_x(b_mxx),
      .min_y(b_mny), .max_y(b_mxy), .center_x(b_cx), .center_y(b_cy), .pixel_count(b_cnt));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // capture every published result, with the cycle it became visible
   always @(negedge clock) begin
      if (s_rv) sq.push_back('{int'(s_found), int'(s_mnx), int'(s_mxx), int'(s_mny),
                               int'(s_mxy), int'(s_cx), int'(s_cy), int'(s_cnt), cyc});
      if (b_rv) bq.push_back('{int'(b_found), int'(b_mnx), int'(b_mxx), int'(b_mny),
                               int'(b_mxy), int'(b_cx), int'(b_cy), int'(b_cnt), cyc});
   end

   task automatic chk(input string tag, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   // Reference: scan each row for maximal mask runs. A run of length L>=R
   // contributes L pixels, its start column, its row, and (if L>R) its end
   // column as a max_x candidate.
   function automatic res_t model(input int W, input int H, input int R, input int M);
      res_t r;
      int mnx = 1023, mxx = 0, mny = 1023, mxy = 0, cnt = 0;
      for (int y = 0; y < H; y++) begin
         int run = 0;
         for (int x = 0; x <= W; x++) begin
            if (x < W && fr[y][x]) run++;
            else begin
               if (run >= R) begin
                  cnt += run;
                  if (x - run < mnx) mnx = x - run;
                  if (run > R && x - 1 > mxx) mxx = x - 1;
                  if (y < mny) mny = y;
                  if (y > mxy) mxy = y;
               end
               run = 0;
            end
         end
      end
      r.cnt = (cnt > 524287) ? 524287 : cnt;
      r.f   = (cnt >= M) ? 1 : 0;
      r.cyc = 0;
      if (r.f != 0) begin
         r.mnx = mnx; r.mxx = mxx; r.mny = mny; r.mxy = mxy;
         r.cx = (mnx + mxx) >> 1; r.cy = (mny + mxy) >> 1;
      end else begin
         r.mnx = 0; r.mxx = 0; r.mny = 0; r.mxy = 0; r.cx = 0; r.cy = 0;
      end
      return r;
   endfunction

   task automatic clr_fr();
      for (int y = 0; y < 64; y++)
         for (int x = 0; x < 256; x++) fr[y][x] = 1'b0;
   endtask

   task automatic solid();
      clr_fr();
      for (int y = 1; y <= 2; y++)
         for (int x = 2; x <= 5; x++) fr[y][x] = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock); #1;
         en = 1'b0; fs = 1'b0;
      end
   endtask

   // Drive the first npix raster pixels of fr; frame_start rides on pixel 0,
   // which is never preceded by a gap. Returns the cycle of the last pixel.
   task automatic frame(input bit big, input int W, input int npix,
                        input int en_pct, output int last_cyc);
      last_cyc = 0;
      for (int i = 0; i < npix; i++) begin
         if (i > 0)
            while ($urandom_range(99) >= en_pct) begin
               @(posedge clock); #1;
               en = 1'b0; fs = 1'b0;
            end
         @(posedge clock); #1;
         sel = big; en = 1'b1; fs = (i == 0); mk = fr[i / W][i % W];
         last_cyc = cyc;
      end
   endtask

   task automatic pop_cmp(input bit big, input string tag, input res_t e, input int last_cyc);
      res_t a;
      if ((big ? bq.size() : sq.size()) == 0) begin
         chk({tag, "_present"}, 0, 1);
      end else begin
         a = big ? bq.pop_front() : sq.pop_front();
         chk({tag, "_lat"},   a.cyc - last_cyc, 2);
         chk({tag, "_found"}, a.f,   e.f);
         chk({tag, "_cnt"},   a.cnt, e.cnt);
         chk({tag, "_minx"},  a.mnx, e.mnx);
         chk({tag, "_maxx"},  a.mxx, e.mxx);
         chk({tag, "_miny"},  a.mny, e.mny);
         chk({tag, "_maxy"},  a.mxy, e.mxy);
         chk({tag, "_cx"},    a.cx,  e.cx);
         chk({tag, "_cy"},    a.cy,  e.cy);
      end
   endtask

   initial begin
      res_t e, e1, e2, es;
      int   l1, l2;

      rst = 1'b1; en = 1'b0; fs = 1'b0; mk = 1'b0; sel = 1'b0;
      clr_fr();
      repeat (3) @(posedge clock);
      #1 rst = 1'b0;
      idle(2);
      chk("rst_rv",  int'(s_rv), 0);
      chk("rst_fnd", int'(s_found), 0);
      chk("rst_cnt", int'(s_cnt), 0);
      chk("rst_box", int'({s_mnx, s_mxx, s_mny, s_mxy, s_cx, s_cy}), 0);

      // solid block, constants straight from the expected box
      es = '{1, 2, 5, 1, 2, 3, 1, 8, 0};
      solid();
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      chk("solid_n", sq.size(), 1);
      pop_cmp(0, "solid", es, l1);

      // isolated noise pixels
      clr_fr(); fr[0][1] = 1; fr[2][4] = 1; fr[3][6] = 1;
      e = model(SW, SH, SR, SM);
      chk("noise_model_cnt", e.cnt, 0);
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      pop_cmp(0, "noise", e, l1);

      // a run split across the line wrap must not count
      clr_fr(); fr[0][7] = 1; fr[1][0] = 1;
      e = model(SW, SH, SR, SM);
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      pop_cmp(0, "wrap", e, l1);

      // found threshold: 2 pixels below, 3 pixels at MIN_PIXELS
      clr_fr(); fr[0][1] = 1; fr[0][2] = 1;
      e = model(SW, SH, SR, SM);
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      pop_cmp(0, "thr2", e, l1);
      clr_fr(); fr[0][1] = 1; fr[0][2] = 1; fr[0][3] = 1;
      e = model(SW, SH, SR, SM);
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      pop_cmp(0, "thr3", e, l1);

      // abort at (3,2) by restarting the frame there
      solid();
      frame(0, SW, 3 + 2 * SW, 100, l1);
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      chk("abort_n", sq.size(), 1);
      pop_cmp(0, "abort", es, l1);

      // random masks with EN gaps
      for (int k = 0; k < 6; k++) begin
         int dens = 30 + 15 * k;
         clr_fr();
         for (int y = 0; y < SH; y++)
            for (int x = 0; x < SW; x++) fr[y][x] = ($urandom_range(99) < dens);
         e = model(SW, SH, SR, SM);
         frame(0, SW, SW * SH, 70, l1);
         idle(4);
         chk("rnd_n", sq.size(), 1);
         pop_cmp(0, $sformatf("rnd%0d", k), e, l1);
      end

      // larger raster: 100x10 box with EN gaps, then an empty frame back-to-back
      clr_fr();
      for (int y = 50; y <= 59; y++)
         for (int x = 100; x <= 199; x++) fr[y][x] = 1'b1;
      e1 = model(BW, BH, BR, BM);
      chk("box_model_cx",  e1.cx, 149);
      chk("box_model_cy",  e1.cy, 54);
      chk("box_model_cnt", e1.cnt, 1000);
      frame(1, BW, BW * BH, 75, l1);
      clr_fr();
      e2 = model(BW, BH, BR, BM);
      frame(1, BW, BW * BH, 75, l2);
      idle(4);
      chk("b2b_n", bq.size(), 2);
      pop_cmp(1, "box", e1, l1);
      pop_cmp(1, "empty", e2, l2);

      // reset at pixel (3,1) of a solid frame, after a valid result is held
      solid();
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      pop_cmp(0, "pre_rst", es, l1);
      frame(0, SW, 3 + SW, 100, l1);
      @(posedge clock); #1;
      rst = 1'b1; sel = 1'b0; en = 1'b1; fs = 1'b0; mk = fr[1][3];
      #1;
      chk("mrst_rv",  int'(s_rv), 0);
      chk("mrst_fnd", int'(s_found), 0);
      chk("mrst_cnt", int'(s_cnt), 0);
      chk("mrst_minx", int'(s_mnx), 0);
      chk("mrst_maxx", int'(s_mxx), 0);
      chk("mrst_cxy", int'({s_cx, s_cy}), 0);
      @(posedge clock); #1;
      rst = 1'b0;
      for (int i = 4 + SW; i < SW * SH; i++) begin
         @(posedge clock); #1;
         en = 1'b1; fs = 1'b0; mk = fr[i / SW][i % SW];
      end
      idle(4);
      chk("mrst_nores", sq.size(), 0);
      chk("mrst_cnt_hold", int'(s_cnt), 0);
      frame(0, SW, SW * SH, 100, l1);
      idle(4);
      pop_cmp(0, "post_rst", es, l1);

      $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
      $finish;
   end

endmodule

// File: doc/paddle_bbox_locator.md
# paddle_bbox_locator

Per-frame paddle localizer sitting directly downstream of the line-buffer/mask filter stage in the paddle localization path. It consumes the raster-ordered binary paddle mask stream (one pixel per `EN` cycle) and tracks its own column/row position. It rejects isolated noise by counting only horizontal runs of at least `RUN_MIN` mask pixels. At end of frame it publishes the paddle bounding box, centre and pixel count, with a one-cycle `result_valid` pulse.

## Interface
- `WIDTH`, 640: active pixels per line.
- `HEIGHT`, 480: active lines per frame.
- `RUN_MIN`, 4: minimum consecutive mask pixels in a row for those pixels to count (1..WIDTH).
- `MIN_PIXELS`, 64: minimum counted pixels for `found`=1.
- `clock`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `EN`  in  1  pixel-valid strobe; one pixel consumed per cycle with `EN`=1.
- `frame_start`  in  1  single-cycle pulse marking the first pixel of a frame.
- `mask_in`  in  1  paddle mask bit for the current pixel, sampled when `EN`=1.
- `result_valid`  out  1  one-cycle pulse: new result published.
- `found`  out  1  counted pixels ≥ `MIN_PIXELS` in last completed frame.
- `min_x`, `max_x`  out  10  bounding-box columns.
- `min_y`, `max_y`  out  10  bounding-box rows.
- `center_x`, `center_y`  out  10  box centre.
- `pixel_count`  out  19  counted pixels, saturating at 2^19-1.

## Operation
- FSM states: IDLE, ACCUM, DONE. Reset enters IDLE.
- IDLE: ignore `EN` and `mask_in` until `frame_start`=1.
- Any state, `frame_start`=1: go to ACCUM and clear `x`, `y`, run counter, accumulators.
    - If `EN`=1 in the same cycle, that pixel is (0,0) and is processed.
    - `frame_start` during ACCUM aborts the current frame; no result is published.
- ACCUM, each `EN`=1 cycle:
    - Position update: `x` increments. At `x`=WIDTH-1, `x`←0 and `y` increments. The run counter clears at end of line.
    - Run counter: `mask_in`=1 increments it, saturating at `RUN_MIN`. `mask_in`=0 clears it.
    - Run reaching `RUN_MIN`: the run's `RUN_MIN` pixels count at once. `count += RUN_MIN`, min_x candidate is `x-RUN_MIN+1`, and `y` updates the y range.
    - Run already at `RUN_MIN`: each further mask pixel adds 1 and `x` is the max_x candidate.
    - min/max accumulators are initialised to min=1023, max=0.
- ACCUM, `EN`=1 at (`WIDTH-1`, `HEIGHT-1`): go to DONE. This pixel is fully processed.
- DONE (one cycle):
    - Latch outputs and pulse `result_valid`, then go to IDLE.
    - `found` = `count` ≥ `MIN_PIXELS`.
    - `found`=1: box outputs take the accumulator values; `center` = (min+max)>>1 with an 11-bit intermediate sum.
    - `found`=0: min/max/center outputs are 0; `pixel_count` still shows the raw count.
    - `frame_start` during DONE: `result_valid` still pulses for the completed frame, and the FSM goes to ACCUM instead of IDLE.
- Published outputs hold until the next DONE or `reset`.
- `EN`=0 cycles freeze all state; there is no timeout.

## Timing
- Reset values: all outputs 0; FSM in IDLE; accumulators at initial values.
- Asserting `reset` mid-frame clears everything immediately; no result is published for that frame.
- Latency: `result_valid` and the new outputs appear at the rising edge that ends the DONE cycle, i.e. 2 clocks after the edge sampling the last pixel. This holds regardless of `EN` in the DONE cycle.
- Minimum frame spacing: the next `frame_start` may coincide with DONE (back-to-back frames, zero idle).
- Throughput: one pixel per clock sustained.

## Test plan
Tests 1–4 use `WIDTH`=8, `HEIGHT`=4, `RUN_MIN`=2, `MIN_PIXELS`=3.

- **Solid block.** Mask=1 at x=2..5 in rows 1..2, `EN` continuous.
    - Required: single `result_valid` 2 clocks after pixel (7,3); `found`=1.
    - Box: min_x=2, max_x=5, min_y=1, max_y=2, center=(3,1), pixel_count=8.
- **Noise rejection.** Isolated mask pixels at (1,0), (4,2), (6,3) only.
    - Required: pixel_count=0, `found`=0, all box outputs 0.
- **Line-wrap run.** Mask=1 at (7,0) and (0,1) only.
    - Required: run counter clears at end of line, so pixel_count=0.
- **Abort.** Mask pattern as the solid block, with `frame_start` re-asserted at pixel (3,2).
    - Required: no `result_valid` for the aborted frame; a following clean frame produces correct results.
- **EN gaps and back-to-back.** Default parameters, `EN` toggling randomly, a box x=100..199 / y=50..59, and the next `frame_start` during DONE.
    - Required: center=(149,54), pixel_count=1000.
    - Second frame (empty) gives `found`=0 exactly one frame later.
- **Reset mid-frame.** Assert `reset` at pixel (3,1).
    - Required: all outputs 0 immediately, FSM returns to IDLE, and pixels ignored until `frame_start`.
